// File: rtl/seq_rca_if.sv
// Handshake and data bundle for seq_rca: operand side (in_*) and result side (out_*).
// The ovf signal only exists when SEQ_RCA_OVF_EN is defined.
interface seq_rca_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             c_out;
`ifdef SEQ_RCA_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, s, c_out
`ifdef SEQ_RCA_OVF_EN
    , ovf
`endif
  );

  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, s, c_out
`ifdef SEQ_RCA_OVF_EN
    , ovf
`endif
  );
endinterface

// File: rtl/seq_rca.sv
// Multi-cycle ripple-carry adder: {c_out, s} = a + b + c_in, SLICE bits per clock.
// Optional signed-overflow output enabled by defining SEQ_RCA_OVF_EN.
module seq_rca #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input logic    clk,
  input logic    rst,
  seq_rca_if.slave bus
);
  localparam int NSLICE = (SLICE >= 1) ? WIDTH / SLICE : 1;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  generate
    if (SLICE < 1) begin : g_bad_slice
      $error("seq_rca: SLICE must be >= 1");
    end else if (WIDTH % SLICE != 0) begin : g_bad_width
      $error("seq_rca: WIDTH must be a multiple of SLICE");
    end
  endgenerate

  logic [1:0]       state_reg;
  logic [IDXW-1:0]  idx_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic             c_out_reg;
`ifdef SEQ_RCA_OVF_EN
  logic             ovf_reg;
`endif

  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE-1:0] sum_sl;
  // chain[k] is the carry into bit k of the current slice; chain[SLICE] leaves it.
  logic [SLICE:0]   chain;

  assign a_sl     = a_reg[idx_reg*SLICE +: SLICE];
  assign b_sl     = b_reg[idx_reg*SLICE +: SLICE];
  assign chain[0] = carry_reg;

  genvar gi;
  generate
    for (gi = 0; gi < SLICE; gi++) begin : g_fa
      assign sum_sl[gi]    = a_sl[gi] ^ b_sl[gi] ^ chain[gi];
      assign chain[gi + 1] = (a_sl[gi] & b_sl[gi]) | (chain[gi] & (a_sl[gi] ^ b_sl[gi]));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      c_out_reg <= 1'b0;
`ifdef SEQ_RCA_OVF_EN
      ovf_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg     <= bus.a;
            b_reg     <= bus.b;
            carry_reg <= bus.c_in;
            sum_reg   <= '0;
            idx_reg   <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          sum_reg[idx_reg*SLICE +: SLICE] <= sum_sl;
          carry_reg <= chain[SLICE];
          if (idx_reg == LAST_IDX) begin
            c_out_reg <= chain[SLICE];
`ifdef SEQ_RCA_OVF_EN
            // Overflow: carry into the MSB differs from carry out of it.
            ovf_reg   <= chain[SLICE-1] ^ chain[SLICE];
`endif
            state_reg <= DONE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.s         = sum_reg;
  assign bus.c_out     = c_out_reg;
`ifdef SEQ_RCA_OVF_EN
  assign bus.ovf       = ovf_reg;
`endif

endmodule

// File: tb/tb_seq_rca.sv
// Self-checking bench for seq_rca: SLICE=4 and SLICE=16 instances against an arithmetic model.
// Define SEQ_RCA_OVF_EN for both RTL and bench to also check ovf.
module tb_seq_rca;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_rca_if #(.WIDTH(W)) bus4 ();
  seq_rca_if #(.WIDTH(W)) bus16 ();

  seq_rca #(.WIDTH(W), .SLICE(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));
  seq_rca #(.WIDTH(W), .SLICE(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    int unsigned r;
    r = int'(a) + int'(b) + int'(ci);
    return r[W:0];
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    int r;
    r = int'($signed(a)) + int'($signed(b)) + int'(ci);
    return (r > 32767) || (r < -32768);
  endfunction

  task automatic check_result4(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    logic [W:0] e;
    e = ref_sum(a, b, ci);
    check({tag, "_s"}, 32'(bus4.s), 32'(e[W-1:0]));
    check({tag, "_cout"}, 32'(bus4.c_out), 32'(e[W]));
`ifdef SEQ_RCA_OVF_EN
    check({tag, "_ovf"}, 32'(bus4.ovf), 32'(ref_ovf(a, b, ci)));
`endif
  endtask

  task automatic do_add4(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input int hold, input bit early, input bit poke);
    int n;
    check("in_ready_idle", 32'(bus4.in_ready), 32'd1);
    bus4.a = a; bus4.b = b; bus4.c_in = ci; bus4.in_valid = 1'b1; bus4.out_ready = 1'b0;
    @(negedge clk);
    bus4.in_valid = 1'b0;
    bus4.a = W'($urandom); bus4.b = W'($urandom); bus4.c_in = 1'($urandom);
    if (early) bus4.out_ready = 1'b1;
    check("in_ready_run", 32'(bus4.in_ready), 32'd0);
    n = 0;
    while (!bus4.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'd4);
    check_result4("res", a, b, ci);
    for (int h = 0; h < hold; h++) begin
      if (poke && h == 1) begin
        bus4.a = 16'h0001; bus4.b = 16'h0000; bus4.c_in = 1'b0; bus4.in_valid = 1'b1;
      end
      @(negedge clk);
      bus4.in_valid = 1'b0;
      check("hold_valid", 32'(bus4.out_valid), 32'd1);
      check("hold_in_ready", 32'(bus4.in_ready), 32'd0);
      check_result4("hold", a, b, ci);
    end
    bus4.out_ready = 1'b1;
    @(negedge clk);
    bus4.out_ready = 1'b0;
    check("in_ready_after", 32'(bus4.in_ready), 32'd1);
    check("valid_after", 32'(bus4.out_valid), 32'd0);
    check_result4("kept", a, b, ci);
    $display("add4 a=%04h b=%04h ci=%0d -> s=%04h c_out=%0d lat=%0d hold=%0d", a, b, ci, bus4.s, bus4.c_out, n, hold);
  endtask

  task automatic do_add16(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    logic [W:0] e;
    e = ref_sum(a, b, ci);
    check("in_ready16", 32'(bus16.in_ready), 32'd1);
    bus16.a = a; bus16.b = b; bus16.c_in = ci; bus16.in_valid = 1'b1;
    @(negedge clk);
    bus16.in_valid = 1'b0;
    bus16.a = W'($urandom); bus16.b = W'($urandom);
    check("valid16_run", 32'(bus16.out_valid), 32'd0);
    @(negedge clk);
    check("valid16_lat", 32'(bus16.out_valid), 32'd1);
    check("s16", 32'(bus16.s), 32'(e[W-1:0]));
    check("cout16", 32'(bus16.c_out), 32'(e[W]));
`ifdef SEQ_RCA_OVF_EN
    check("ovf16", 32'(bus16.ovf), 32'(ref_ovf(a, b, ci)));
`endif
    bus16.out_ready = 1'b1;
    @(negedge clk);
    bus16.out_ready = 1'b0;
    check("in_ready16_after", 32'(bus16.in_ready), 32'd1);
    $display("add16 a=%04h b=%04h ci=%0d -> s=%04h c_out=%0d", a, b, ci, bus16.s, bus16.c_out);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    logic [W-1:0] ra, rb;
    rst = 1'b1;
    bus4.in_valid = 0; bus4.a = 0; bus4.b = 0; bus4.c_in = 0; bus4.out_ready = 0;
    bus16.in_valid = 0; bus16.a = 0; bus16.b = 0; bus16.c_in = 0; bus16.out_ready = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", 32'(bus4.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus4.out_valid), 32'd0);
    check("rst_s", 32'(bus4.s), 32'd0);
    check("rst_cout", 32'(bus4.c_out), 32'd0);
`ifdef SEQ_RCA_OVF_EN
    check("rst_ovf", 32'(bus4.ovf), 32'd0);
`endif
    check("rst_in_ready16", 32'(bus16.in_ready), 32'd1);

    do_add4(16'h1234, 16'h4321, 1'b0, 0, 1'b0, 1'b0);
    do_add4(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0, 1'b0);
    do_add4(16'hFFFF, 16'hFFFF, 1'b1, 0, 1'b0, 1'b0);
    do_add4(16'hABCD, 16'h1111, 1'b1, 6, 1'b0, 1'b1);
    do_add4(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, 1'b0);

    // Reset while idx=2; c_out=1 is still held from the previous add.
    bus4.a = 16'h1111; bus4.b = 16'h2222; bus4.c_in = 1'b0; bus4.in_valid = 1'b1;
    @(negedge clk);
    bus4.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_valid", 32'(bus4.out_valid), 32'd0);
    check("midrst_s", 32'(bus4.s), 32'd0);
    check("midrst_cout", 32'(bus4.c_out), 32'd0);
    check("midrst_in_ready", 32'(bus4.in_ready), 32'd1);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus4.out_valid) seen = 1'b1;
    end
    check("midrst_no_result", 32'(seen), 32'd0);
    $display("reset mid-run: discarded in-flight add");
    do_add4(16'h00FF, 16'h0001, 1'b0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      int hold;
      bit early;
      case ($urandom_range(0, 3))
        0: ra = 16'hFFFF;
        1: ra = 16'h7FFF;
        2: ra = 16'h8000;
        default: ra = W'($urandom);
      endcase
      rb = ($urandom_range(0, 3) == 0) ? 16'h0001 : W'($urandom);
      early = 1'($urandom_range(0, 1));
      hold = early ? 0 : $urandom_range(0, 3);
      do_add4(ra, rb, 1'($urandom), hold, early, 1'b1);
    end

    do_add16(16'h8000, 16'h8000, 1'b1);
    do_add16(16'h7FFF, 16'h0001, 1'b0);
    for (int i = 0; i < 6; i++) begin
      do_add16(W'($urandom), W'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
